// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file
// Machine-mode CSR file. Answers combinational CSR reads from execute,
// applies committed writes from writeback, and handles trap entry and MRET
// side effects. Also maintains mcycle/minstret, synchronizes the interrupt
// lines into MIP, and reports the pending interrupt and trap vector.
//
// Ports:
//   clock, reset              clock; asynchronous active-low reset
//   readCSR / readData        4-bit CSR select, 32-bit combinational read
//   writeEnable/writeCSR/writeData   committed CSR write
//   retire                    one instruction retired (minstret increment)
//   trapEnter/trapPC/trapCause/trapValue   trap entry and its saved state
//   mretCommit                MRET retired
//   external/timer/softwareInterrupt      asynchronous interrupt lines
//   interruptRequest/interruptCause       enabled pending interrupt + cause
//   trapVector, mepcOut       MTVEC (direct mode) and MEPC
// ---------------------------------------------------------------------------
module csr_file #(
  parameter logic [31:0] MTVEC_RESET     = 32'h0000_0000,
  parameter int          COUNTERS_ENABLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  readCSR,
  output logic [31:0] readData,
  input  logic        writeEnable,
  input  logic [3:0]  writeCSR,
  input  logic [31:0] writeData,
  input  logic        retire,
  input  logic        trapEnter,
  input  logic [31:0] trapPC,
  input  logic [31:0] trapCause,
  input  logic [31:0] trapValue,
  input  logic        mretCommit,
  input  logic        externalInterrupt,
  input  logic        timerInterrupt,
  input  logic        softwareInterrupt,
  output logic        interruptRequest,
  output logic [31:0] interruptCause,
  output logic [31:0] trapVector,
  output logic [31:0] mepcOut
);

  localparam logic [3:0] CSR_MSTATUS  = 4'd0;
  localparam logic [3:0] CSR_MIE      = 4'd1;
  localparam logic [3:0] CSR_MTVEC    = 4'd2;
  localparam logic [3:0] CSR_MSCRATCH = 4'd3;
  localparam logic [3:0] CSR_MEPC     = 4'd4;
  localparam logic [3:0] CSR_MCAUSE   = 4'd5;
  localparam logic [3:0] CSR_MTVAL    = 4'd6;
  localparam logic [3:0] CSR_MIP      = 4'd7;
  localparam logic [3:0] CSR_MCYCLE   = 4'd8;
  localparam logic [3:0] CSR_MINSTRET = 4'd9;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Architectural state. MSTATUS and MIE only keep their writable bits;
  // the read mux rebuilds the full 32-bit view.
  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_meie;
  logic        mie_mtie;
  logic        mie_msie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [31:0] mcycle;
  logic [31:0] minstret;

  // Interrupt synchronizers: stage 1 may go metastable, stage 2 is MIP.
  logic [2:0]  irq_sync1;
  logic [2:0]  irq_sync2;
  logic [31:0] mip;
  logic [31:0] mie_view;
  logic [31:0] mstatus_view;
  logic [31:0] pending;

  logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc;
  logic wr_mcause, wr_mtval, wr_mcycle, wr_minstret;

  assign wr_mstatus  = writeEnable && (writeCSR == CSR_MSTATUS);
  assign wr_mie      = writeEnable && (writeCSR == CSR_MIE);
  assign wr_mtvec    = writeEnable && (writeCSR == CSR_MTVEC);
  assign wr_mscratch = writeEnable && (writeCSR == CSR_MSCRATCH);
  assign wr_mepc     = writeEnable && (writeCSR == CSR_MEPC);
  assign wr_mcause   = writeEnable && (writeCSR == CSR_MCAUSE);
  assign wr_mtval    = writeEnable && (writeCSR == CSR_MTVAL);
  assign wr_mcycle   = writeEnable && (writeCSR == CSR_MCYCLE);
  assign wr_minstret = writeEnable && (writeCSR == CSR_MINSTRET);

  // Bit order of the sync vectors: [2]=external, [1]=timer, [0]=software.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_sync1 <= 3'b000;
      irq_sync2 <= 3'b000;
    end else begin
      irq_sync1 <= {externalInterrupt, timerInterrupt, softwareInterrupt};
      irq_sync2 <= irq_sync1;
    end
  end

  // MSTATUS: trap entry beats MRET, which beats a software write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trapEnter) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mretCommit) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_mstatus) begin
      mstatus_mie  <= writeData[3];
      mstatus_mpie <= writeData[7];
    end
  end

  // Trap-saved registers: a trap in the same cycle drops the CSR write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mepc   <= 32'h0;
      mcause <= 32'h0;
      mtval  <= 32'h0;
    end else if (trapEnter) begin
      mepc   <= trapPC & ALIGN_MASK;
      mcause <= trapCause;
      mtval  <= trapValue;
    end else begin
      if (wr_mepc)   mepc   <= writeData & ALIGN_MASK;
      if (wr_mcause) mcause <= writeData;
      if (wr_mtval)  mtval  <= writeData;
    end
  end

  // Plain software-written CSRs, untouched by traps.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mie_meie <= 1'b0;
      mie_mtie <= 1'b0;
      mie_msie <= 1'b0;
      mtvec    <= MTVEC_RESET & ALIGN_MASK;
      mscratch <= 32'h0;
    end else begin
      if (wr_mie) begin
        mie_meie <= writeData[11];
        mie_mtie <= writeData[7];
        mie_msie <= writeData[3];
      end
      if (wr_mtvec)    mtvec    <= writeData & ALIGN_MASK;
      if (wr_mscratch) mscratch <= writeData;
    end
  end

  // Counters: a same-cycle write replaces the increment; both wrap naturally.
  generate
    if (COUNTERS_ENABLE != 0) begin : g_counters
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          mcycle   <= 32'h0;
          minstret <= 32'h0;
        end else begin
          if (wr_mcycle) mcycle <= writeData;
          else           mcycle <= mcycle + 32'd1;
          if (wr_minstret) minstret <= writeData;
          else if (retire) minstret <= minstret + 32'd1;
        end
      end
    end else begin : g_no_counters
      assign mcycle   = 32'h0;
      assign minstret = 32'h0;
    end
  endgenerate

  assign mip          = {20'h0, irq_sync2[2], 3'b000, irq_sync2[1], 3'b000,
                         irq_sync2[0], 3'b000};
  assign mie_view     = {20'h0, mie_meie, 3'b000, mie_mtie, 3'b000,
                         mie_msie, 3'b000};
  assign mstatus_view = {19'h0, 2'b11, 3'b000, mstatus_mpie, 3'b000,
                         mstatus_mie, 3'b000};
  assign pending      = mip & mie_view;

  always_comb begin
    readData = 32'h0;
    case (readCSR)
      CSR_MSTATUS:  readData = mstatus_view;
      CSR_MIE:      readData = mie_view;
      CSR_MTVEC:    readData = mtvec;
      CSR_MSCRATCH: readData = mscratch;
      CSR_MEPC:     readData = mepc;
      CSR_MCAUSE:   readData = mcause;
      CSR_MTVAL:    readData = mtval;
      CSR_MIP:      readData = mip;
      CSR_MCYCLE:   readData = mcycle;
      CSR_MINSTRET: readData = minstret;
      default:      readData = 32'h0;
    endcase
  end

  // Priority MEI > MSI > MTI; cause reflects enabled pending lines even
  // while the global MIE bit masks the request itself.
  always_comb begin
    interruptCause = 32'h0;
    if (pending[11])     interruptCause = CAUSE_MEI;
    else if (pending[3]) interruptCause = CAUSE_MSI;
    else if (pending[7]) interruptCause = CAUSE_MTI;
  end

  assign interruptRequest = mstatus_mie & (|pending);
  assign trapVector       = mtvec;
  assign mepcOut          = mepc;

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// tb_csr_file
// Directed self-checking bench for csr_file with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_csr_file;

  localparam logic [3:0] CSR_MSTATUS  = 4'd0;
  localparam logic [3:0] CSR_MIE      = 4'd1;
  localparam logic [3:0] CSR_MTVEC    = 4'd2;
  localparam logic [3:0] CSR_MSCRATCH = 4'd3;
  localparam logic [3:0] CSR_MEPC     = 4'd4;
  localparam logic [3:0] CSR_MCAUSE   = 4'd5;
  localparam logic [3:0] CSR_MTVAL    = 4'd6;
  localparam logic [3:0] CSR_MIP      = 4'd7;
  localparam logic [3:0] CSR_MCYCLE   = 4'd8;
  localparam logic [3:0] CSR_MINSTRET = 4'd9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  readCSR = 4'd0;
  logic [31:0] readData;
  logic        writeEnable = 1'b0;
  logic [3:0]  writeCSR = 4'd0;
  logic [31:0] writeData = 32'h0;
  logic        retire = 1'b0;
  logic        trapEnter = 1'b0;
  logic [31:0] trapPC = 32'h0;
  logic [31:0] trapCause = 32'h0;
  logic [31:0] trapValue = 32'h0;
  logic        mretCommit = 1'b0;
  logic        externalInterrupt = 1'b0;
  logic        timerInterrupt = 1'b0;
  logic        softwareInterrupt = 1'b0;
  logic        interruptRequest;
  logic [31:0] interruptCause;
  logic [31:0] trapVector;
  logic [31:0] mepcOut;

  int checks = 0;
  int errors = 0;

  csr_file #(
    .MTVEC_RESET     (32'h0000_0203),
    .COUNTERS_ENABLE (1)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .readCSR           (readCSR),
    .readData          (readData),
    .writeEnable       (writeEnable),
    .writeCSR          (writeCSR),
    .writeData         (writeData),
    .retire            (retire),
    .trapEnter         (trapEnter),
    .trapPC            (trapPC),
    .trapCause         (trapCause),
    .trapValue         (trapValue),
    .mretCommit        (mretCommit),
    .externalInterrupt (externalInterrupt),
    .timerInterrupt    (timerInterrupt),
    .softwareInterrupt (softwareInterrupt),
    .interruptRequest  (interruptRequest),
    .interruptCause    (interruptCause),
    .trapVector        (trapVector),
    .mepcOut           (mepcOut)
  );

  always #10 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic readCheck(input string tag, input logic [3:0] csr,
                           input logic [31:0] expected);
    readCSR = csr;
    #1;
    checkOutput(tag, readData, expected);
  endtask

  task automatic applyStimulus(input logic [3:0] csr, input logic [31:0] data);
    writeEnable = 1'b1;
    writeCSR    = csr;
    writeData   = data;
    tick();
    writeEnable = 1'b0;
  endtask

  initial begin
    // Reset state, applied asynchronously before the first clock edge.
    #2 reset = 1'b0;
    #2;
    readCheck("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    checkOutput("rst_trapVector", trapVector, 32'h0000_0200);
    checkOutput("rst_mepcOut", mepcOut, 32'h0);
    checkOutput("rst_irq", {31'h0, interruptRequest}, 32'h0);
    checkOutput("rst_cause", interruptCause, 32'h0);
    #10 reset = 1'b1;

    repeat (5) tick();
    readCheck("idle_mcycle", CSR_MCYCLE, 32'd5);
    readCheck("idle_minstret", CSR_MINSTRET, 32'd0);
    readCheck("idle_mstatus", CSR_MSTATUS, 32'h0000_1800);
    checkOutput("idle_irq", {31'h0, interruptRequest}, 32'h0);

    // Write legalization.
    applyStimulus(CSR_MSTATUS, 32'hFFFF_FFFF);
    readCheck("legal_mstatus", CSR_MSTATUS, 32'h0000_1888);
    applyStimulus(CSR_MTVEC, 32'h8000_0103);
    readCheck("legal_mtvec", CSR_MTVEC, 32'h8000_0100);
    checkOutput("legal_trapVector", trapVector, 32'h8000_0100);
    applyStimulus(CSR_MIE, 32'hFFFF_FFFF);
    readCheck("legal_mie", CSR_MIE, 32'h0000_0888);
    applyStimulus(CSR_MEPC, 32'h0000_0077);
    readCheck("legal_mepc", CSR_MEPC, 32'h0000_0074);
    applyStimulus(CSR_MSCRATCH, 32'h1234_5679);
    readCheck("legal_mscratch", CSR_MSCRATCH, 32'h1234_5679);
    applyStimulus(CSR_MIE, 32'h0000_0800);
    readCheck("mie_ext_only", CSR_MIE, 32'h0000_0800);

    // External interrupt reaches MIP two edges after the line rises.
    externalInterrupt = 1'b1;
    #1;
    checkOutput("ext_irq_edge0", {31'h0, interruptRequest}, 32'h0);
    tick();
    checkOutput("ext_irq_edge1", {31'h0, interruptRequest}, 32'h0);
    tick();
    checkOutput("ext_irq_edge2", {31'h0, interruptRequest}, 32'h1);
    checkOutput("ext_cause", interruptCause, 32'h8000_000B);

    timerInterrupt = 1'b1;
    softwareInterrupt = 1'b1;
    tick();
    tick();
    readCheck("mip_all", CSR_MIP, 32'h0000_0888);
    checkOutput("ext_over_timer_cause", interruptCause, 32'h8000_000B);

    // MSI beats MTI once external drops.
    applyStimulus(CSR_MIE, 32'h0000_0888);
    externalInterrupt = 1'b0;
    tick();
    tick();
    checkOutput("msi_cause", interruptCause, 32'h8000_0003);
    softwareInterrupt = 1'b0;
    tick();
    tick();
    checkOutput("mti_cause", interruptCause, 32'h8000_0007);
    checkOutput("mti_irq", {31'h0, interruptRequest}, 32'h1);

    // Global MIE masks the request.
    applyStimulus(CSR_MSTATUS, 32'h0000_0000);
    checkOutput("masked_irq", {31'h0, interruptRequest}, 32'h0);
    applyStimulus(CSR_MSTATUS, 32'h0000_0088);
    readCheck("mstatus_restore", CSR_MSTATUS, 32'h0000_1888);
    timerInterrupt = 1'b0;
    tick();
    tick();
    checkOutput("none_irq", {31'h0, interruptRequest}, 32'h0);
    checkOutput("none_cause", interruptCause, 32'h0);

    // Trap entry wins over a same-cycle MEPC write.
    trapEnter   = 1'b1;
    trapPC      = 32'h0000_0106;
    trapCause   = 32'h8000_000B;
    trapValue   = 32'h0000_DEAD;
    writeEnable = 1'b1;
    writeCSR    = CSR_MEPC;
    writeData   = 32'h0000_1234;
    tick();
    trapEnter   = 1'b0;
    writeEnable = 1'b0;
    readCheck("trap_mepc", CSR_MEPC, 32'h0000_0104);
    readCheck("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
    readCheck("trap_mcause", CSR_MCAUSE, 32'h8000_000B);
    readCheck("trap_mtval", CSR_MTVAL, 32'h0000_DEAD);

    mretCommit = 1'b1;
    tick();
    mretCommit = 1'b0;
    readCheck("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
    checkOutput("mret_mepcOut", mepcOut, 32'h0000_0104);

    // Trap alongside a write to an unaffected CSR: the write still lands.
    trapEnter   = 1'b1;
    trapPC      = 32'h0000_0200;
    trapCause   = 32'h0000_0002;
    trapValue   = 32'h0000_0BAD;
    writeEnable = 1'b1;
    writeCSR    = CSR_MSCRATCH;
    writeData   = 32'h0000_CAFE;
    tick();
    trapEnter   = 1'b0;
    writeEnable = 1'b0;
    readCheck("trap2_mscratch", CSR_MSCRATCH, 32'h0000_CAFE);
    checkOutput("trap2_mepcOut", mepcOut, 32'h0000_0200);
    readCheck("trap2_mstatus", CSR_MSTATUS, 32'h0000_1880);

    // MRET wins over a same-cycle MSTATUS write.
    mretCommit  = 1'b1;
    writeEnable = 1'b1;
    writeCSR    = CSR_MSTATUS;
    writeData   = 32'h0000_0000;
    tick();
    mretCommit  = 1'b0;
    writeEnable = 1'b0;
    readCheck("mret_over_write", CSR_MSTATUS, 32'h0000_1888);

    // minstret: write overrides the increment, then wraps.
    retire      = 1'b1;
    writeEnable = 1'b1;
    writeCSR    = CSR_MINSTRET;
    writeData   = 32'hFFFF_FFFF;
    tick();
    writeEnable = 1'b0;
    readCheck("minstret_write_wins", CSR_MINSTRET, 32'hFFFF_FFFF);
    tick();
    retire = 1'b0;
    readCheck("minstret_wrap", CSR_MINSTRET, 32'h0);
    tick();
    readCheck("minstret_hold", CSR_MINSTRET, 32'h0);

    // mcycle counts up from a written value, then async reset mid-count.
    applyStimulus(CSR_MCYCLE, 32'h0000_003C);
    repeat (4) tick();
    readCheck("mcycle_count", CSR_MCYCLE, 32'h0000_0040);
    #3 reset = 1'b0;
    #1;
    checkOutput("async_rst_mcycle", readData, 32'h0);
    checkOutput("async_rst_mepcOut", mepcOut, 32'h0);
    checkOutput("async_rst_trapVector", trapVector, 32'h0000_0200);
    readCheck("async_rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    readCheck("async_rst_mscratch", CSR_MSCRATCH, 32'h0);
    #2 reset = 1'b1;
    tick();
    readCheck("mcycle_resume", CSR_MCYCLE, 32'd1);

    // MIP is read-only; reserved selects read zero and ignore writes.
    applyStimulus(CSR_MIP, 32'h0000_FFFF);
    readCheck("mip_readonly", CSR_MIP, 32'h0);
    applyStimulus(4'd12, 32'hFFFF_FFFF);
    readCheck("reserved12", 4'd12, 32'h0);
    readCheck("reserved15", 4'd15, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
